// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-stage bus bundle: decode handshake, branch bus and instruction SRAM port
interface fetch_stage_if;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin,
    input  br_bus,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_req,
    output inst_sram_addr
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_req,
    input  inst_sram_addr
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage; define FETCH_BYPASS_EN to hand SRAM data to decode in its arrival cycle
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        br_pending;
  logic [31:0] br_target_r;

  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_now;
  logic        data_in;
  logic        fs_req;
  logic        fs_valid;
  logic        fs_fire;
  logic [31:0] fs_inst;
  logic [31:0] next_pc;

  assign br_stall  = bus.br_bus[33];
  assign br_taken  = bus.br_bus[32];
  assign br_target = bus.br_bus[31:0];
  assign br_now    = br_taken & ~br_stall;

  // Read data only counts while a request is outstanding; stray data_ok elsewhere is dropped.
  assign data_in = (state == S_WAIT) & bus.inst_sram_data_ok;

  // A stalled decode must not take the word, even if it signals allowin.
  assign fs_fire = fs_valid & bus.ds_allowin & ~br_stall;

  assign bus.inst_sram_req  = fs_req;
  assign bus.inst_sram_addr = fs_pc;
  assign bus.fs_to_ds_valid = fs_valid;
  // The PC half is always driven: decode uses it as the delay-slot PC.
  assign bus.fs_to_ds_bus   = {fs_inst, fs_pc};

  // Live branch wins, then a branch remembered while fetch had nothing valid, else sequential.
  always_comb begin
    next_pc = fs_pc + 32'd4;
    if (br_now) begin
      next_pc = br_target;
    end else if (br_pending) begin
      next_pc = br_target_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs: one request in flight, word presented until decode takes it.
  always_comb begin
    state_nxt = state;
    fs_req    = 1'b0;
    fs_valid  = 1'b0;
    fs_inst   = inst_buf;
    case (state)
      S_REQ: begin
        fs_req = 1'b1;
        if (bus.inst_sram_addr_ok) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.inst_sram_data_ok) begin
`ifdef FETCH_BYPASS_EN
          fs_valid  = 1'b1;
          fs_inst   = bus.inst_sram_rdata;
          state_nxt = (bus.ds_allowin && !br_stall) ? S_REQ : S_HOLD;
`else
          state_nxt = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        fs_valid = 1'b1;
        if (bus.ds_allowin && !br_stall) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Capture returned instruction word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_buf <= 32'd0;
    end else if (data_in) begin
      inst_buf <= bus.inst_sram_rdata;
    end
  end

  // Advance the fetch PC only when decode accepts the current word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_pc <= RESET_PC;
    end else if (fs_fire) begin
      fs_pc <= next_pc;
    end
  end

  // Remember a taken branch until the next handoff consumes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_pending  <= 1'b0;
      br_target_r <= 32'd0;
    end else begin
      if (fs_fire) begin
        br_pending <= 1'b0;
      end else if (br_now) begin
        br_pending <= 1'b1;
      end
      if (br_now) begin
        br_target_r <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with a transaction-level reference model
module tb_fetch_stage;

`ifdef FETCH_BYPASS_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  logic clk;
  logic resetn;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks;
  int n_errors;
  int cyc;

  logic sram_auto;
  int   sram_lat;

  logic [31:0] hs_pc[$];
  logic [31:0] hs_inst[$];
  int          hs_cyc[$];

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_tgt;
  logic        m_out;
  logic        m_have;
  logic        m_pend;
  logic        exp_req;
  logic        cur_valid;
  logic [31:0] cur_inst;
  logic        arrive;
  logic        stall;
  logic        br_now;
  logic        fire;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int which, input string name);
    for (int i = 0; i < 60; i++) begin
      if ((which == 0 && bus.fs_to_ds_valid) || (which == 1 && bus.inst_sram_req)) return;
      step();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=no event in 60 cycles required=event", name);
  endtask

  task automatic wait_hs(input int n, input string name);
    for (int i = 0; i < 60; i++) begin
      if (hs_pc.size() >= n) return;
      step();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=%0d handoffs required=%0d", name, hs_pc.size(), n);
  endtask

  // Instruction SRAM: accepts immediately, returns data sram_lat cycles after acceptance.
  initial begin : sram_responder
    logic        pend;
    int          cnt;
    logic [31:0] a;
    logic        auto_l;
    pend = 1'b0;
    cnt  = 0;
    a    = 32'd0;
    forever begin
      @(negedge clk);
      auto_l = sram_auto;
      if (auto_l && resetn && bus.inst_sram_req && bus.inst_sram_addr_ok && !pend) begin
        pend = 1'b1;
        cnt  = sram_lat;
        a    = bus.inst_sram_addr;
      end
      @(posedge clk);
      #1;
      if (auto_l) begin
        bus.inst_sram_addr_ok = 1'b1;
        if (pend && cnt <= 1) begin
          bus.inst_sram_data_ok = 1'b1;
          bus.inst_sram_rdata   = mem(a);
          pend = 1'b0;
        end else begin
          bus.inst_sram_data_ok = 1'b0;
          if (pend) cnt--;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Reference model: one outstanding fetch, a held word until decode takes it, branch redirect rules.
  always @(negedge clk) begin : compare
    cyc++;
    if (!resetn) begin
      check("valid_in_reset", 64'(bus.fs_to_ds_valid), 64'd0);
      check("bus_in_reset", bus.fs_to_ds_bus, {32'd0, 32'hBFC0_0000});
      m_pc   = 32'hBFC0_0000;
      m_inst = 32'd0;
      m_tgt  = 32'd0;
      m_out  = 1'b0;
      m_have = 1'b0;
      m_pend = 1'b0;
    end else begin
      exp_req   = !m_out && !m_have;
      cur_valid = m_have;
      cur_inst  = m_inst;
      arrive    = m_out && bus.inst_sram_data_ok;
`ifdef FETCH_BYPASS_EN
      if (arrive) begin
        cur_valid = 1'b1;
        cur_inst  = bus.inst_sram_rdata;
      end
`endif
      check("req", 64'(bus.inst_sram_req), 64'(exp_req));
      if (exp_req) check("addr", 64'(bus.inst_sram_addr), 64'(m_pc));
      check("valid", 64'(bus.fs_to_ds_valid), 64'(cur_valid));
      check("bus_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'(m_pc));
      if (cur_valid) check("bus_inst", 64'(bus.fs_to_ds_bus[63:32]), 64'(cur_inst));
      stall  = bus.br_bus[33];
      br_now = bus.br_bus[32] && !stall;
      fire   = cur_valid && bus.ds_allowin && !stall;
      if (fire) begin
        hs_pc.push_back(m_pc);
        hs_inst.push_back(cur_inst);
        hs_cyc.push_back(cyc);
        m_pc   = br_now ? bus.br_bus[31:0] : (m_pend ? m_tgt : m_pc + 32'd4);
        m_pend = 1'b0;
        m_have = 1'b0;
      end else if (br_now) begin
        m_pend = 1'b1;
        m_tgt  = bus.br_bus[31:0];
      end
      if (arrive) begin
        m_out = 1'b0;
        if (!fire) begin
          m_have = 1'b1;
          m_inst = bus.inst_sram_rdata;
        end
      end else if (exp_req && bus.inst_sram_addr_ok) begin
        m_out = 1'b1;
      end
    end
  end

  initial begin : stimulus
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    resetn   = 1'b0;
    sram_auto = 1'b1;
    sram_lat  = 1;
    bus.ds_allowin        = 1'b1;
    bus.br_bus            = 34'd0;
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'd0;

    step();
    step();
    step();
    check("rst_valid", 64'(bus.fs_to_ds_valid), 64'd0);
    check("rst_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'hBFC0_0000);
    resetn = 1'b1;
    check("first_req", 64'(bus.inst_sram_req), 64'd1);
    check("first_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0000);

    // Sequential fetch at full rate.
    wait_hs(3, "seq_handoffs");
    if (hs_pc.size() >= 3) begin
      check("seq_pc0", 64'(hs_pc[0]), 64'hBFC0_0000);
      check("seq_pc1", 64'(hs_pc[1]), 64'hBFC0_0004);
      check("seq_pc2", 64'(hs_pc[2]), 64'hBFC0_0008);
      check("seq_inst0", 64'(hs_inst[0]), 64'h616D_BEEF);
      check("seq_rate01", 64'(hs_cyc[1] - hs_cyc[0]), 64'(PERIOD));
      check("seq_rate12", 64'(hs_cyc[2] - hs_cyc[1]), 64'(PERIOD));
    end

    // Decode back-pressure: word held, no new request.
    bus.ds_allowin = 1'b0;
    wait_sig(0, "hold_valid");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid_stays", 64'(bus.fs_to_ds_valid), 64'd1);
      check("hold_no_req", 64'(bus.inst_sram_req), 64'd0);
      check("hold_bus", bus.fs_to_ds_bus, {32'h616D_BEE3, 32'hBFC0_000C});
      step();
    end

    // Branch resolving at the delay-slot handoff.
    bus.ds_allowin = 1'b1;
    step();
    bus.ds_allowin = 1'b0;
    wait_sig(0, "ds_valid");
    check("ds_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'hBFC0_0010);
    bus.ds_allowin = 1'b1;
    bus.br_bus     = {2'b01, 32'hBFC0_0100};
    step();
    bus.br_bus     = 34'd0;
    bus.ds_allowin = 1'b0;
    wait_sig(1, "br_req");
    check("br_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0100);
    wait_sig(0, "br_tgt_valid");
    bus.ds_allowin = 1'b1;
    step();
    bus.ds_allowin = 1'b0;
    wait_sig(1, "after_br_req");
    check("after_br_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0104);

    // Stalled decode blocks the handoff; the later unstalled branch redirects.
    sram_lat = 3;
    wait_sig(0, "stall_valid");
    bus.ds_allowin = 1'b1;
    bus.br_bus     = {2'b11, 32'hDEAD_DEAD};
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 64'(bus.fs_to_ds_valid), 64'd1);
      check("stall_no_req", 64'(bus.inst_sram_req), 64'd0);
      check("stall_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'hBFC0_0104);
    end
    bus.br_bus = {2'b01, 32'hBFC0_0200};
    step();
    bus.br_bus     = 34'd0;
    bus.ds_allowin = 1'b0;
    wait_sig(1, "stall_br_req");
    check("stall_br_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0200);

    // Branch pulse while the fetch is still waiting on SRAM.
    step();
    bus.br_bus     = {2'b01, 32'hBFC0_0300};
    bus.ds_allowin = 1'b1;
    step();
    bus.br_bus = 34'd0;
    check("wait_no_valid", 64'(bus.fs_to_ds_valid), 64'd0);
    wait_sig(1, "pend_req");
    check("pend_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0300);
    if (hs_pc.size() > 0) check("pend_last_pc", 64'(hs_pc[hs_pc.size() - 1]), 64'hBFC0_0200);

    // Reset while waiting on SRAM, stale data_ok afterwards.
    bus.ds_allowin = 1'b0;
    sram_lat       = 1;
    wait_sig(0, "pre_rst_valid");
    sram_auto = 1'b0;
    step();
    step();
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.ds_allowin        = 1'b1;
    step();
    bus.ds_allowin = 1'b0;
    check("man_req", 64'(bus.inst_sram_req), 64'd1);
    check("man_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0304);
    bus.inst_sram_addr_ok = 1'b1;
    step();
    bus.inst_sram_addr_ok = 1'b0;
    check("man_wait_no_req", 64'(bus.inst_sram_req), 64'd0);
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus.fs_to_ds_valid), 64'd0);
    step();
    step();
    hs_pc.delete();
    hs_inst.delete();
    hs_cyc.delete();
    resetn = 1'b1;
    step();
    bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata   = 32'h1234_5678;
    step();
    bus.inst_sram_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_valid", 64'(bus.fs_to_ds_valid), 64'd0);
      check("stale_req", 64'(bus.inst_sram_req), 64'd1);
      check("stale_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0000);
      step();
    end
    sram_auto      = 1'b1;
    bus.ds_allowin = 1'b1;
    wait_hs(2, "post_rst_handoffs");
    if (hs_pc.size() >= 2) begin
      check("post_rst_pc0", 64'(hs_pc[0]), 64'hBFC0_0000);
      check("post_rst_pc1", 64'(hs_pc[1]), 64'hBFC0_0004);
      check("post_rst_inst1", 64'(hs_inst[1]), 64'h616D_BEEB);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

endmodule
